// File: rtl/sensor_pkg.sv
// Shared types and default parameters for the vehicle-loop sensor conditioner.
package sensor_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL    = 3'd1,
    PRESENT = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } sens_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 8;
  localparam int DEF_STUCK_CYCLES    = 1000;
  localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/sensor_channel.sv
// One loop-detector channel: 2-flop synchroniser, debounce/hold/stuck FSM and
// a shared counter; sen and fault are registered.
module sensor_channel
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic sen,
  output logic fault
);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] QUAL_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_LIMIT = CNT_W'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FAULT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             s;
  sens_state_t      state;
  sens_state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_a <= raw;
      s      <= sync_a;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sen   <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sen   <= (state_next == PRESENT) || (state_next == HOLD) || (state_next == FAULT);
      fault <= (state_next == FAULT);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (s) begin
          state_next = QUAL;
          cnt_next   = CNT_ONE;
        end
      end
      QUAL: begin
        // The IDLE sample already counted as the first; ">=" lets a one-cycle
        // debounce pass straight through on the next sample.
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt >= QUAL_LAST) begin
          state_next = PRESENT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      PRESENT: begin
        if (!s) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else if (cnt == STUCK_LIMIT) begin
          state_next = FAULT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HOLD: begin
        // Re-entering PRESENT without re-qualifying keeps demand continuous.
        if (s) begin
          state_next = PRESENT;
          cnt_next   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      FAULT: begin
        if (s) begin
          cnt_next = '0;
        end else if (cnt == FAULT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Two independent loop-detector channels feeding the traffic controller's
// sen1/sen2 demand inputs.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw1,
  input  logic raw2,
  output logic sen1,
  output logic sen2,
  output logic fault1,
  output logic fault2
);

  sensor_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch1 (
    .clk  (clk),
    .reset(reset),
    .raw  (raw1),
    .sen  (sen1),
    .fault(fault1)
  );

  sensor_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch2 (
    .clk  (clk),
    .reset(reset),
    .raw  (raw2),
    .sen  (sen2),
    .fault(fault2)
  );

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed latency scenarios plus randomized run-length stimulus against a
// run-length reference model of the conditioned demand.
module tb_sensor_conditioner;

  localparam int D = 4;
  localparam int H = 8;
  localparam int S = 32;

  logic clk = 1'b0;
  logic reset;
  logic raw1, raw2;
  logic sen1, sen2, fault1, fault2;

  int checks = 0;
  int errors = 0;

  // Reference model: sync pipeline plus consecutive high/low run lengths.
  logic m_ff1[2], m_ff2[2];
  int   hr[2], lr[2], prun[2];
  logic m_sen[2], m_fault[2];

  always #5 clk = ~clk;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .STUCK_CYCLES   (S),
    .CNT_W          (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .raw1  (raw1),
    .raw2  (raw2),
    .sen1  (sen1),
    .sen2  (sen2),
    .fault1(fault1),
    .fault2(fault2)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_ff1[c] = 1'b0; m_ff2[c] = 1'b0;
      hr[c] = 0; lr[c] = 0; prun[c] = 0;
      m_sen[c] = 1'b0; m_fault[c] = 1'b0;
    end
  endtask

  task automatic model_step(input int c, input logic r);
    logic s;
    s = m_ff2[c];
    m_ff2[c] = m_ff1[c];
    m_ff1[c] = r;
    if (s) begin hr[c]++; lr[c] = 0; end
    else   begin lr[c]++; hr[c] = 0; end
    if (m_fault[c]) begin
      if (lr[c] == D) begin m_fault[c] = 1'b0; m_sen[c] = 1'b0; end
    end else if (m_sen[c]) begin
      if (s) begin
        prun[c] = (hr[c] == 1) ? 0 : prun[c] + 1;
        if (prun[c] == S + 1) m_fault[c] = 1'b1;
      end else if (lr[c] == H + 1) begin
        m_sen[c] = 1'b0;
      end
    end else if (s && hr[c] == D) begin
      m_sen[c] = 1'b1;
      prun[c] = 0;
    end
  endtask

  task automatic cycle(input logic r1, input logic r2);
    @(negedge clk);
    raw1 = r1;
    raw2 = r2;
    @(posedge clk);
    model_step(0, r1);
    model_step(1, r2);
    #1;
    check("sen1", sen1, m_sen[0]);
    check("sen2", sen2, m_sen[1]);
    check("fault1", fault1, m_fault[0]);
    check("fault2", fault2, m_fault[1]);
    $display("cyc t=%0t raw=%b%b sen=%b%b fault=%b%b", $time, r1, r2, sen1, sen2, fault1, fault2);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop before any edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check({tag, "_sen1"}, sen1, 0);
    check({tag, "_sen2"}, sen2, 0);
    check({tag, "_fault1"}, fault1, 0);
    check({tag, "_fault2"}, fault2, 0);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, {sen1, sen2, fault1, fault2}, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int idx, idx2, seen, dips;
    int rem[2];
    logic val[2];

    reset = 1'b1;
    raw1  = 1'b0;
    raw2  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {sen1, sen2, fault1, fault2}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Assertion latency on road 1; road 2 untouched.
    idx = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0);
      if (idx < 0 && sen1) idx = i;
    end
    check("lat_on", idx, D + 1);

    // Release latency through the hold window.
    idx = -1;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0);
      if (idx < 0 && !sen1) idx = i;
    end
    check("lat_off", idx, H + 2);

    // A pulse shorter than the debounce window never asserts demand.
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(i < 3, 1'b0);
      if (sen1) seen = 1;
    end
    check("short_pulse", seen, 0);

    // A gap shorter than the hold window keeps demand continuous.
    seen = 0;
    dips = 0;
    for (int i = 0; i < 25; i++) begin
      cycle((i < 10) || (i >= 15), 1'b0);
      if (sen1) seen = 1;
      else if (seen != 0) dips++;
    end
    check("hold_gap", dips, 0);
    repeat (15) cycle(1'b0, 1'b0);

    // Stuck loop on road 2, then recovery.
    idx = -1;
    idx2 = -1;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 1'b1);
      if (idx < 0 && sen2) idx = i;
      if (idx2 < 0 && fault2) idx2 = i;
    end
    check("stuck_sen", idx, D + 1);
    check("stuck_fault", idx2, D + 1 + S + 1);
    idx = -1;
    idx2 = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0);
      if (idx < 0 && !fault2) idx = i;
      if (idx2 < 0 && !sen2) idx2 = i;
    end
    check("fault_clear", idx, D + 1);
    check("fault_sen_clear", idx2, D + 1);

    // Reset while road 2 is PRESENT and road 1 is in HOLD.
    repeat (10) cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1);
    pulse_reset("midrst");
    repeat (12) cycle(1'b1, 1'b0);

    // Randomized run lengths per channel, including runs long enough to stick.
    rem[0] = 0; rem[1] = 0;
    val[0] = 1'b0; val[1] = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          val[c] = ~val[c];
          case ($urandom_range(0, 9))
            0, 1, 2: rem[c] = $urandom_range(1, D + 2);
            3, 4, 5, 6: rem[c] = $urandom_range(1, H + 4);
            7, 8: rem[c] = $urandom_range(H, 2 * H + 4);
            default: rem[c] = $urandom_range(S, S + D + 10);
          endcase
        end
        rem[c]--;
      end
      cycle(val[0], val[1]);
      if ($urandom_range(0, 599) == 0) pulse_reset("rndrst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
